// File: rtl/alu_dispatch_pkg.sv
// Shared types and helpers for the ALU dispatch unit: FSM state encoding and
// extraction of one latency field from the packed per-unit latency vector.
package alu_dispatch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } disp_state_t;

  localparam int unsigned DEFAULT_LAT_W = 3;

  // Wide enough for any NUM_UNITS * LAT_W the dispatch unit is built with.
  localparam int unsigned LatVecW = 256;
  typedef logic [LatVecW-1:0] lat_vec_t;

  function automatic int unsigned lat_of(input lat_vec_t    unit_lat,
                                         input int unsigned sel,
                                         input int unsigned lat_w = DEFAULT_LAT_W);
    lat_vec_t mask;
    mask = (lat_vec_t'(1) << lat_w) - lat_vec_t'(1);
    return 32'((unit_lat >> (sel * lat_w)) & mask);
  endfunction

endpackage

// File: rtl/alu_dispatch_unit_if.sv
// Operation/result handshake bundle between the operand stage, the dispatch
// unit and the result consumer.
interface alu_dispatch_unit_if #(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned SEL_W     = $clog2(NUM_UNITS)
);
  logic                 Op_Valid;
  logic                 Op_Ready;
  logic [SEL_W-1:0]     ALU_FUN_SEL;
  logic [NUM_UNITS-1:0] Unit_Enable;
  logic                 Result_Valid;
  logic                 Result_Ready;
  logic [SEL_W-1:0]     Result_Sel;
  logic                 Illegal_Sel;
  logic                 Err_Clr;
  logic                 Busy;

  modport master (
    output Op_Valid, ALU_FUN_SEL, Result_Ready, Err_Clr,
    input  Op_Ready, Unit_Enable, Result_Valid, Result_Sel, Illegal_Sel, Busy
  );

  modport slave (
    input  Op_Valid, ALU_FUN_SEL, Result_Ready, Err_Clr,
    output Op_Ready, Unit_Enable, Result_Valid, Result_Sel, Illegal_Sel, Busy
  );
endinterface

// File: rtl/onehot_decoder.sv
// Combinational select-to-one-hot decoder; legal is low for selects that do
// not address an existing unit, in which case onehot is all zero.
module onehot_decoder #(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned SEL_W     = $clog2(NUM_UNITS)
) (
  input  logic [SEL_W-1:0]     sel,
  output logic [NUM_UNITS-1:0] onehot,
  output logic                 legal
);

  always_comb begin
    onehot = '0;
    legal  = (32'(sel) < NUM_UNITS);
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      onehot[i] = (32'(sel) == i);
    end
  end

endmodule

// File: rtl/alu_dispatch_unit.sv
// Registered ALU dispatch: accepts one op at a time, pulses (or holds) a
// one-hot unit enable and raises Result_Valid once the unit's latency expires.
module alu_dispatch_unit
  import alu_dispatch_pkg::*;
#(
  parameter int unsigned                 NUM_UNITS = 4,
  parameter int unsigned                 SEL_W     = $clog2(NUM_UNITS),
  parameter int unsigned                 LAT_W     = DEFAULT_LAT_W,
  parameter logic [NUM_UNITS*LAT_W-1:0]  UNIT_LAT  = {3'd4, 3'd3, 3'd2, 3'd1},
  parameter bit                          HOLD_EN   = 1'b0
) (
  input logic               CLK,
  input logic               RST,
  alu_dispatch_unit_if.slave bus
);

  localparam logic [LAT_W-1:0] CntOne = LAT_W'(1);

  disp_state_t          state_q, state_d;
  logic [LAT_W-1:0]     cnt_q, cnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_UNITS-1:0] en_q, en_d;
  logic                 ill_q, ill_d;

  logic [NUM_UNITS-1:0] dec_onehot;
  logic                 dec_legal;
  logic [LAT_W-1:0]     sel_lat;
  logic                 op_ready;
  logic                 accept;
  logic                 load;

  onehot_decoder #(
    .NUM_UNITS (NUM_UNITS),
    .SEL_W     (SEL_W)
  ) u_dec (
    .sel    (bus.ALU_FUN_SEL),
    .onehot (dec_onehot),
    .legal  (dec_legal)
  );

  always_comb begin
    sel_lat = LAT_W'(lat_of(lat_vec_t'(UNIT_LAT), 32'(bus.ALU_FUN_SEL), LAT_W));
  end

  always_comb begin
    op_ready = (state_q == StIdle) || ((state_q == StDone) && bus.Result_Ready);
    accept   = bus.Op_Valid && op_ready;
  end

  // ISSUE already counts as one latency cycle, so the result is due L cycles
  // after acceptance (never sooner than 2).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    en_d    = HOLD_EN ? en_q : '0;
    ill_d   = ill_q;
    load    = 1'b0;

    if (bus.Err_Clr) begin
      ill_d = 1'b0;
    end
    if (accept && !dec_legal) begin
      ill_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (accept && dec_legal) begin
          load = 1'b1;
        end
      end
      StIssue: begin
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CntOne;
        state_d = (cnt_q <= CntOne) ? StDone : StWait;
      end
      StWait: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.Result_Ready) begin
          state_d = StIdle;
          en_d    = '0;
          if (accept && dec_legal) begin
            load = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        en_d    = '0;
      end
    endcase

    if (load) begin
      state_d = StIssue;
      sel_d   = bus.ALU_FUN_SEL;
      cnt_d   = sel_lat - CntOne;
      en_d    = dec_onehot;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= '0;
      en_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.Op_Ready     = op_ready;
  assign bus.Unit_Enable  = en_q;
  assign bus.Result_Valid = (state_q == StDone);
  assign bus.Result_Sel   = sel_q;
  assign bus.Illegal_Sel  = ill_q;
  assign bus.Busy         = (state_q != StIdle);

endmodule

// File: tb/tb_alu_dispatch_unit.sv
// Directed bench for alu_dispatch_unit: default 4-unit build, a 3-unit build
// for illegal selects and a HOLD_EN build, plus a random one-hot sweep.
module tb_alu_dispatch_unit;

  logic CLK;
  logic RST;

  int unsigned vectors;
  int unsigned miscompares;

  alu_dispatch_unit_if #(.NUM_UNITS(4)) bus4 ();
  alu_dispatch_unit_if #(.NUM_UNITS(3)) bus3 ();
  alu_dispatch_unit_if #(.NUM_UNITS(4)) bush ();

  alu_dispatch_unit #(.NUM_UNITS(4)) dut4 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus4)
  );

  alu_dispatch_unit #(
    .NUM_UNITS (3),
    .UNIT_LAT  ({3'd3, 3'd2, 3'd1})
  ) dut3 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus3)
  );

  alu_dispatch_unit #(
    .NUM_UNITS (4),
    .HOLD_EN   (1'b1)
  ) duth (
    .CLK (CLK),
    .RST (RST),
    .bus (bush)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST = 1'b1;
    bus4.Op_Valid = 1'b0; bus4.ALU_FUN_SEL = '0; bus4.Result_Ready = 1'b0; bus4.Err_Clr = 1'b0;
    bus3.Op_Valid = 1'b0; bus3.ALU_FUN_SEL = '0; bus3.Result_Ready = 1'b0; bus3.Err_Clr = 1'b0;
    bush.Op_Valid = 1'b0; bush.ALU_FUN_SEL = '0; bush.Result_Ready = 1'b0; bush.Err_Clr = 1'b0;

    // Reset values
    #2;
    check("rst_ue",   32'(bus4.Unit_Enable), 0);
    check("rst_rv",   32'(bus4.Result_Valid), 0);
    check("rst_sel",  32'(bus4.Result_Sel), 0);
    check("rst_ill",  32'(bus4.Illegal_Sel), 0);
    check("rst_busy", 32'(bus4.Busy), 0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_rdy", 32'(bus4.Op_Ready), 1);

    // Unit 0, latency 1
    bus4.Op_Valid = 1'b1; bus4.ALU_FUN_SEL = 2'd0;
    tick();
    bus4.Op_Valid = 1'b0;
    check("u0_ue_n1",   32'(bus4.Unit_Enable), 32'h1);
    check("u0_rv_n1",   32'(bus4.Result_Valid), 0);
    check("u0_busy_n1", 32'(bus4.Busy), 1);
    tick();
    check("u0_ue_n2",  32'(bus4.Unit_Enable), 0);
    check("u0_rv_n2",  32'(bus4.Result_Valid), 1);
    check("u0_sel_n2", 32'(bus4.Result_Sel), 0);
    bus4.Result_Ready = 1'b1;
    #1;
    check("u0_rdy_done", 32'(bus4.Op_Ready), 1);
    tick();
    bus4.Result_Ready = 1'b0;
    check("u0_busy_end", 32'(bus4.Busy), 0);
    check("u0_rv_end",   32'(bus4.Result_Valid), 0);

    // Unit 3, latency 4, consumer stalls; an op offered while busy is ignored
    bus4.Op_Valid = 1'b1; bus4.ALU_FUN_SEL = 2'd3;
    tick();
    bus4.Op_Valid = 1'b0;
    check("u3_ue_n1", 32'(bus4.Unit_Enable), 32'h8);
    check("u3_rv_n1", 32'(bus4.Result_Valid), 0);
    tick();
    bus4.Op_Valid = 1'b1; bus4.ALU_FUN_SEL = 2'd1;
    #1;
    check("u3_rdy_busy", 32'(bus4.Op_Ready), 0);
    check("u3_ue_n2",    32'(bus4.Unit_Enable), 0);
    tick();
    bus4.Op_Valid = 1'b0;
    check("u3_rv_n3",  32'(bus4.Result_Valid), 0);
    check("u3_sel_n3", 32'(bus4.Result_Sel), 3);
    tick();
    check("u3_rv_n4",  32'(bus4.Result_Valid), 1);
    check("u3_sel_n4", 32'(bus4.Result_Sel), 3);
    tick();
    check("u3_rv_n5",  32'(bus4.Result_Valid), 1);
    tick();
    check("u3_rv_n6",  32'(bus4.Result_Valid), 1);
    check("u3_sel_n6", 32'(bus4.Result_Sel), 3);
    bus4.Result_Ready = 1'b1;
    tick();
    check("u3_busy_end", 32'(bus4.Busy), 0);
    check("u3_rdy_end",  32'(bus4.Op_Ready), 1);
    check("u3_rv_end",   32'(bus4.Result_Valid), 0);
    bus4.Result_Ready = 1'b0;

    // Back-to-back: sel 2 (L=3), then sel 1 (L=2) accepted in the DONE cycle
    bus4.Op_Valid = 1'b1; bus4.ALU_FUN_SEL = 2'd2;
    tick();
    bus4.Op_Valid = 1'b0;
    check("b2b_ue_n1", 32'(bus4.Unit_Enable), 32'h4);
    tick();
    check("b2b_rv_n2", 32'(bus4.Result_Valid), 0);
    tick();
    check("b2b_rv_n3",  32'(bus4.Result_Valid), 1);
    check("b2b_sel_n3", 32'(bus4.Result_Sel), 2);
    bus4.Result_Ready = 1'b1; bus4.Op_Valid = 1'b1; bus4.ALU_FUN_SEL = 2'd1;
    #1;
    check("b2b_rdy_done", 32'(bus4.Op_Ready), 1);
    tick();
    bus4.Op_Valid = 1'b0; bus4.Result_Ready = 1'b0;
    check("b2b_ue_n4",   32'(bus4.Unit_Enable), 32'h2);
    check("b2b_rv_n4",   32'(bus4.Result_Valid), 0);
    check("b2b_busy_n4", 32'(bus4.Busy), 1);
    check("b2b_sel_n4",  32'(bus4.Result_Sel), 1);
    tick();
    check("b2b_rv_n5", 32'(bus4.Result_Valid), 1);
    check("b2b_ue_n5", 32'(bus4.Unit_Enable), 0);
    bus4.Result_Ready = 1'b1;
    tick();
    bus4.Result_Ready = 1'b0;
    check("b2b_busy_end", 32'(bus4.Busy), 0);

    // Illegal select on the 3-unit build
    bus3.Op_Valid = 1'b1; bus3.ALU_FUN_SEL = 2'd3;
    #1;
    check("ill_rdy", 32'(bus3.Op_Ready), 1);
    tick();
    bus3.Op_Valid = 1'b0;
    check("ill_set",  32'(bus3.Illegal_Sel), 1);
    check("ill_ue",   32'(bus3.Unit_Enable), 0);
    check("ill_busy", 32'(bus3.Busy), 0);
    bus3.Err_Clr = 1'b1;
    tick();
    bus3.Err_Clr = 1'b0;
    check("ill_clr", 32'(bus3.Illegal_Sel), 0);
    bus3.Op_Valid = 1'b1; bus3.ALU_FUN_SEL = 2'd3; bus3.Err_Clr = 1'b1;
    tick();
    bus3.Op_Valid = 1'b0; bus3.Err_Clr = 1'b0;
    check("ill_set_wins", 32'(bus3.Illegal_Sel), 1);
    bus3.Op_Valid = 1'b1; bus3.ALU_FUN_SEL = 2'd2;
    tick();
    bus3.Op_Valid = 1'b0;
    check("ill_legal_ue", 32'(bus3.Unit_Enable), 32'h4);

    // HOLD_EN build, sel 1 (L=2), one stall cycle before acceptance
    bush.Op_Valid = 1'b1; bush.ALU_FUN_SEL = 2'd1;
    tick();
    bush.Op_Valid = 1'b0;
    check("hold_ue_n1", 32'(bush.Unit_Enable), 32'h2);
    check("hold_rv_n1", 32'(bush.Result_Valid), 0);
    tick();
    check("hold_ue_n2", 32'(bush.Unit_Enable), 32'h2);
    check("hold_rv_n2", 32'(bush.Result_Valid), 1);
    tick();
    check("hold_ue_n3", 32'(bush.Unit_Enable), 32'h2);
    bush.Result_Ready = 1'b1;
    tick();
    bush.Result_Ready = 1'b0;
    check("hold_ue_end",   32'(bush.Unit_Enable), 0);
    check("hold_busy_end", 32'(bush.Busy), 0);

    // Asynchronous reset mid-WAIT (unit 3 on both 4-unit builds)
    bus4.Op_Valid = 1'b1; bus4.ALU_FUN_SEL = 2'd3;
    bush.Op_Valid = 1'b1; bush.ALU_FUN_SEL = 2'd3;
    tick();
    bus4.Op_Valid = 1'b0; bush.Op_Valid = 1'b0;
    tick();
    check("arst_pre_busy", 32'(bus4.Busy), 1);
    check("arst_pre_ueh",  32'(bush.Unit_Enable), 32'h8);
    #2;
    RST = 1'b1;
    #1;
    check("arst_busy", 32'(bus4.Busy), 0);
    check("arst_sel",  32'(bus4.Result_Sel), 0);
    check("arst_rv",   32'(bus4.Result_Valid), 0);
    check("arst_ueh",  32'(bush.Unit_Enable), 0);
    check("arst_busyh", 32'(bush.Busy), 0);
    check("arst_ill3", 32'(bus3.Illegal_Sel), 0);
    #3;
    RST = 1'b0;
    #1;
    check("arst_rdy",  32'(bus4.Op_Ready), 1);
    check("arst_rdyh", 32'(bush.Op_Ready), 1);

    // Random traffic: the enable must never be multi-hot
    for (int i = 0; i < 3000; i++) begin
      bus4.Op_Valid     = 1'($urandom_range(0, 1));
      bus4.ALU_FUN_SEL  = 2'($urandom_range(0, 3));
      bus4.Result_Ready = 1'($urandom_range(0, 1));
      bus4.Err_Clr      = 1'($urandom_range(0, 1));
      bus3.Op_Valid     = 1'($urandom_range(0, 1));
      bus3.ALU_FUN_SEL  = 2'($urandom_range(0, 3));
      bus3.Result_Ready = 1'($urandom_range(0, 1));
      bus3.Err_Clr      = 1'($urandom_range(0, 1));
      bush.Op_Valid     = 1'($urandom_range(0, 1));
      bush.ALU_FUN_SEL  = 2'($urandom_range(0, 3));
      bush.Result_Ready = 1'($urandom_range(0, 1));
      tick();
      check("rand_onehot4", 32'($onehot0(bus4.Unit_Enable)), 1);
      check("rand_onehot3", 32'($onehot0(bus3.Unit_Enable)), 1);
      check("rand_onehoth", 32'($onehot0(bush.Unit_Enable)), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
